uart_tx_arbiter: RTL

- Shares the single UART transmit datapath (8-bit parallel byte + one-cycle start strobe into the UART core) between NUM_REQ byte-stream requesters.
- Grants the transmitter for a whole frame, terminated by `last`, so frames from different requesters never interleave.
- Uses round-robin fairness and an optional per-frame source-ID header byte.
- Sits between FPGA-side producers and the UART IP TX port; the UART core keeps handling RTS/CTS.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter and related UART glue.
// Optional header-byte feature is controlled by UART_ARB_HEADER_EN in the
// arbiter top; this package is the same for both builds.
package uart_pkg;

   localparam int         UART_BYTE_W = 8;
   localparam logic [3:0] HDR_TAG     = 4'hA;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      DATA  = 3'd2,
      GAP   = 3'd3,
      DRAIN = 3'd4
   } arb_state_e;

   // Frame header byte: tag nibble, a zero bit, then the 3-bit source id.
   function automatic logic [UART_BYTE_W-1:0] hdr_byte(input logic [2:0] id);
      return {HDR_TAG, 1'b0, id};
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder: returns the first set bit of
// req searching ptr, ptr+1, ... wrapping modulo NUM_REQ. ptr must be < NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   int pos;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      pos = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end
         if (|(req & (NUM_REQ'(1) << pos))) begin
            idx = ID_W'(pos);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit port between NUM_REQ byte
// streams. A grant lasts for a whole frame (up to and including req_last).
// Define UART_ARB_HEADER_EN to prefix every frame with the byte 8'hA0 | id.
//
// Handshake: a requester byte transfers on a rising edge where both
// req_valid[i] and req_ready[i] are high; valid must not depend on ready.
// req_ready is decoded from state and grant_id only.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 3
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [UART_BYTE_W-1:0] tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic                   frame_active,
   output logic [ID_W-1:0]        grant_id,
   output logic [2:0]             state_dbg
);

   arb_state_e             state_q, state_d;
   logic [ID_W-1:0]        grant_q, grant_d;
   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic                   active_q, active_d;
   logic [UART_BYTE_W-1:0] data_q, data_d;
   logic                   start_q, start_d;
   logic                   last_q, last_d;

   logic [ID_W-1:0]        pick_idx;
   logic                   pick_any;
   logic                   own_valid;
   logic                   own_last;
   logic [UART_BYTE_W-1:0] own_data;
   logic [ID_W-1:0]        next_ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Mux the current owner's byte lane out of the flattened request bus.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == ID_W'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[i*8 +: 8];
         end
      end
   end

   // Only the owner sees ready, and only while waiting for its next byte.
   always_comb begin
      req_ready = '0;
      if (state_q == DATA) begin
         req_ready = NUM_REQ'(1) << grant_q;
      end
   end

   assign next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

   // Next-state and registered-output decode; tx_start is a one-cycle pulse.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      active_d = active_q;
      data_d   = data_q;
      start_d  = 1'b0;
      last_d   = last_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d  = pick_idx;
               active_d = 1'b1;
`ifdef UART_ARB_HEADER_EN
               state_d  = HDR;
`else
               state_d  = DATA;
`endif
            end
         end
`ifdef UART_ARB_HEADER_EN
         HDR: begin
            // Clearing last_flag makes DRAIN always return to DATA after the header.
            data_d  = hdr_byte(3'(grant_q));
            start_d = 1'b1;
            last_d  = 1'b0;
            state_d = GAP;
         end
`endif
         DATA: begin
            if (own_valid) begin
               data_d  = own_data;
               start_d = 1'b1;
               last_d  = own_last;
               state_d = GAP;
            end
         end
         GAP: begin
            // tx_busy has not risen yet for the byte just started.
            state_d = DRAIN;
         end
         DRAIN: begin
            if (!tx_busy) begin
               if (last_q) begin
                  active_d = 1'b0;
                  ptr_d    = next_ptr;
                  state_d  = IDLE;
               end else begin
                  state_d  = DATA;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         ptr_q    <= '0;
         active_q <= 1'b0;
         data_q   <= '0;
         start_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         active_q <= active_d;
         data_q   <= data_d;
         start_q  <= start_d;
         last_q   <= last_d;
      end
   end

   assign tx_data      = data_q;
   assign tx_start     = start_q;
   assign frame_active = active_q;
   assign grant_id     = grant_q;
   assign state_dbg    = state_q;

endmodule
